// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-back, write-allocate L1 cache.
//
// The core-facing port answers word reads and writes. Hits are serviced in the
// request cycle, with no stall. A miss stalls the core. If the victim line is
// dirty, the cache first writes that line back. It then allocates the requested
// 128-bit block from the block memory and returns to COMPARE, where the held
// request hits.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset (control state only)
//   proc_read        word read request, held while proc_stall is high
//   proc_write       word write request, held while proc_stall is high
//   proc_addr[29:0]  word address {tag, index, word}
//   proc_wdata[31:0] write data
//   proc_stall       high while the presented request is not yet serviced
//   proc_rdata[31:0] read data, valid when proc_read=1 and proc_stall=0
//   mem_read         block read request (level, held until mem_ready)
//   mem_write        block write request (level, held until mem_ready)
//   mem_addr[27:0]   block address {tag, index}
//   mem_wdata[127:0] block write data, word 0 in [31:0]
//   mem_ready        single-cycle acknowledge from the block memory
//   mem_rdata[127:0] block read data, valid with mem_ready
module l1_cache #(
  parameter int INDEX_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  localparam int TAG_W = 28 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         word;
  logic [127:0]       line;
  logic               request;
  logic               hit;
  logic               hit_write;
  logic               fill;

  assign idx     = proc_addr[INDEX_W+1:2];
  assign req_tag = proc_addr[29:INDEX_W+2];
  assign word    = proc_addr[1:0];
  assign line    = data_mem[idx];
  assign request = proc_read | proc_write;
  assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

  // Read data is taken straight from the indexed line. It is only meaningful
  // when proc_read is high and proc_stall is low.
  assign proc_rdata = line[{word, 5'd0} +: 32];

  // The memory requests are decoded from the registered state only. This keeps
  // mem_read and mem_write mutually exclusive. It also holds them, together with
  // the address and write block, stable until the memory acknowledges.
  always_comb begin
    state_next = state;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = {req_tag, idx};
    mem_wdata  = line;
    hit_write  = 1'b0;
    fill       = 1'b0;
    case (state)
      COMPARE: begin
        if (request) begin
          if (hit) begin
            // A write wins when both requests are raised together.
            hit_write = proc_write;
          end else begin
            proc_stall = 1'b1;
            state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_mem[idx], idx};
        if (mem_ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          fill       = 1'b1;
          state_next = COMPARE;
        end
      end
      default: state_next = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COMPARE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (hit_write) dirty[idx] <= 1'b1;
    end
  end

  // Tags and data carry no reset. Writes are blocked during reset so that a
  // late mem_ready seen while rst_n is low cannot fill a line.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill) begin
        tag_mem[idx]  <= req_tag;
        data_mem[idx] <= mem_rdata;
      end
      if (hit_write) data_mem[idx][{word, 5'd0} +: 32] <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: self-checking bench for l1_cache.
// A block-memory responder with programmable latency sits on the memory port.
// A flat word-addressed reference memory predicts what every core read must
// return. The bench runs a directed transaction table, a reset-during-allocate
// sequence, and randomized traffic ending in a flush-by-conflict sweep.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;

  l1_cache #(.INDEX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Block memory: contents default to a fixed function of the word address.
  logic [127:0] phys [logic [27:0]];
  logic [31:0]  refm [logic [29:0]];
  logic [27:0]  wr_log [$];
  logic [27:0]  rd_log [$];
  int           wr_cnt = 0;
  int           rd_cnt = 0;
  int           lat = 1;
  int           cnt = 0;
  bit           auto_mem = 1'b1;
  logic         man_ready = 1'b0;
  logic [127:0] man_rdata = '0;
  bit           both_seen = 1'b0;

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {2'b01, a} ^ 32'h3C3C_A5A5;
  endfunction

  function automatic logic [127:0] blk_read(input logic [27:0] b);
    if (phys.exists(b)) return phys[b];
    return {init_word({b, 2'd3}), init_word({b, 2'd2}),
            init_word({b, 2'd1}), init_word({b, 2'd0})};
  endfunction

  function automatic logic [31:0] phys_word(input logic [29:0] a);
    logic [127:0] blk;
    blk = blk_read(a[29:2]);
    return blk[{a[1:0], 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    if (refm.exists(a)) return refm[a];
    return phys_word(a);
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Responder: a request that is high for 'lat' cycles is acknowledged in its
  // last cycle. The decision is made on the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_seen = 1'b1;
    if (!auto_mem) begin
      mem_ready = man_ready;
      mem_rdata = man_rdata;
      cnt = 0;
    end else begin
      if (mem_ready) cnt = 0;
      mem_ready = 1'b0;
      if (rst_n && (mem_read || mem_write)) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          if (mem_write) begin
            phys[mem_addr] = mem_wdata;
            wr_cnt++;
            wr_log.push_back(mem_addr);
          end else begin
            mem_rdata = blk_read(mem_addr);
            rd_cnt++;
            rd_log.push_back(mem_addr);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_req(input logic r, input logic w, input logic [29:0] a,
                        input logic [31:0] d, output int stalls,
                        output logic [31:0] rd, output bit ok);
    proc_read = r; proc_write = w; proc_addr = a; proc_wdata = d;
    stalls = 0; ok = 1'b0; rd = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!proc_stall) begin
        rd = proc_rdata;
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  logic [24:0] tag_pool [4] = '{25'h0, 25'h1, 25'h2, 25'h1FF_FFFF};

  initial begin
    vec_t tbl[8];
    int st, w0, r0;
    logic [31:0] rdv;
    bit ok;
    logic [29:0] a;
    logic [31:0] d;
    logic r, w;

    phys[28'h4] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    //            rd    wr    addr      wdata         lat stall chk   rdata                  wr rd
    tbl[0] = '{1'b1, 1'b0, 30'h010, 32'h0,         3, 4, 1'b1, 32'hAAAAAAAA,          0, 1};
    tbl[1] = '{1'b1, 1'b0, 30'h011, 32'h0,         3, 0, 1'b1, 32'hBBBBBBBB,          0, 0};
    tbl[2] = '{1'b0, 1'b1, 30'h011, 32'h12345678,  3, 0, 1'b0, 32'h0,                 0, 0};
    tbl[3] = '{1'b1, 1'b0, 30'h111, 32'h0,         2, 5, 1'b1, init_word(30'h111),    1, 1};
    tbl[4] = '{1'b1, 1'b0, 30'h011, 32'h0,         1, 2, 1'b1, 32'h12345678,          0, 1};
    tbl[5] = '{1'b0, 1'b1, 30'h022, 32'hCAFEF00D,  4, 5, 1'b0, 32'h0,                 0, 1};
    tbl[6] = '{1'b1, 1'b0, 30'h022, 32'h0,         4, 0, 1'b1, 32'hCAFEF00D,          0, 0};
    tbl[7] = '{1'b1, 1'b1, 30'h122, 32'h0BADBEEF,  2, 5, 1'b0, 32'h0,                 1, 1};

    apply_reset();
    @(negedge clk);
    check("reset_stall", proc_stall, 0);
    check("reset_mem_read", mem_read, 0);
    check("reset_mem_write", mem_write, 0);
    @(posedge clk); #1;

    // Directed transaction table
    for (int i = 0; i < 8; i++) begin
      lat = tbl[i].lat; w0 = wr_cnt; r0 = rd_cnt;
      do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, st, rdv, ok);
      check($sformatf("vec%0d_done", i), ok, 1);
      check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdv, tbl[i].exp_rdata);
      check($sformatf("vec%0d_memwr", i), wr_cnt - w0, tbl[i].exp_wr);
      check($sformatf("vec%0d_memrd", i), rd_cnt - r0, tbl[i].exp_rd);
    end
    check("wb_count", wr_log.size(), 2);
    check("wb0_addr", wr_log[0], 28'h4);
    check("wb1_addr", wr_log[1], 28'h8);
    check("alloc_after_wb_addr", rd_log[1], 28'h44);
    check("wb0_merged_word", phys[28'h4][63:32], 32'h12345678);
    check("wb0_other_word", phys[28'h4][31:0], 32'hAAAAAAAA);
    check("wb1_merged_word", phys[28'h8][95:64], 32'hCAFEF00D);
    check("wb1_other_word", phys[28'h8][31:0], init_word(30'h020));
    // The read+write of 0x122 acted as a write: a hit read now returns that data.
    lat = 1;
    do_req(1'b1, 1'b0, 30'h122, 32'h0, st, rdv, ok);
    check("both_as_write", rdv, 32'h0BADBEEF);
    check("both_as_write_stall", st, 0);

    // Reset during ALLOCATE, then a late mem_ready
    auto_mem = 1'b0; man_ready = 1'b0;
    apply_reset();
    proc_read = 1'b1; proc_addr = 30'h010;
    @(negedge clk);
    check("rst_seq_miss_stall", proc_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_alloc_read", mem_read, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; proc_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; man_ready = 1'b1; man_rdata = {4{32'hDEADDEAD}};
    @(negedge clk);
    check("rst_seq_mem_read", mem_read, 0);
    check("rst_seq_mem_write", mem_write, 0);
    check("rst_seq_stall", proc_stall, 0);
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(posedge clk); #1;
    auto_mem = 1'b1; lat = 2;
    do_req(1'b1, 1'b0, 30'h010, 32'h0, st, rdv, ok);
    check("rst_seq_remiss_stall", st, 3);
    check("rst_seq_rdata", rdv, phys_word(30'h010));
    do_req(1'b1, 1'b0, 30'h122, 32'h0, st, rdv, ok);
    check("rst_seq_line0_invalid", st, 3);

    // Random traffic against the flat reference memory
    for (int n = 0; n < 400; n++) begin
      lat = $urandom_range(1, 8);
      a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d = $urandom;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 2) == 0);
      if (!r && !w) r = 1'b1;
      do_req(r, w, a, d, st, rdv, ok);
      check("rand_done", ok, 1);
      if (w) refm[a] = d;
      else check($sformatf("rand_read_%0h", a), rdv, ref_word(a));
    end

    // Flush every line by reading a tag that was never used
    for (int i = 0; i < 8; i++) begin
      lat = $urandom_range(1, 8);
      a = {25'h0000123, 3'(i), 2'd0};
      do_req(1'b1, 1'b0, a, 32'h0, st, rdv, ok);
      check("flush_read", rdv, ref_word(a));
    end
    foreach (refm[k]) check($sformatf("final_mem_%0h", k), phys_word(k), refm[k]);
    check("req_exclusive", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-back, write-allocate L1 cache that is the responder for the pipeline core's cache port (ren/wen/addr/wdata in; stall/rdata out). One instance serves the I-side and one the D-side. On the far side it acts as initiator to a slow 128-bit block memory through a level request / single-cycle ready handshake.

## Interface
- INDEX_W, 3: index bits; line count = 2^INDEX_W (8 lines); tag width = 28 − INDEX_W.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- proc_read  in  1  word read request; held until proc_stall is low.
- proc_write  in  1  word write request; held until proc_stall is low.
- proc_addr  in  30  word address: [1:0] word-in-line, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  in  32  write data.
- proc_stall  out  1  high while the current request is not yet serviced.
- proc_rdata  out  32  read data; valid in the cycle proc_read is high and proc_stall is low.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_addr  out  28  block address {tag, index}.
- mem_wdata  out  128  block write data; word 0 in [31:0].
- mem_ready  in  1  one-cycle acknowledge from memory.
- mem_rdata  in  128  block read data; valid when mem_ready is high.

## Operation
- Per line: valid bit, dirty bit, tag, 4×32-bit data. Reset clears all valid and dirty bits; data and tag contents are don't-care.
- FSM states: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE, no request: proc_stall=0, no state change.
- COMPARE, hit (valid and tag equal): proc_stall=0 in the same cycle. A read drives proc_rdata from the selected word combinationally. A write updates the word and sets dirty at the clock edge.
- COMPARE, miss, victim clean or invalid: proc_stall=1, go to ALLOCATE.
- COMPARE, miss, victim valid and dirty: proc_stall=1, go to WRITEBACK.
- WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim block. All three are held stable until mem_ready is sampled high; then go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_addr={request tag, index}, held until mem_ready. On mem_ready, write mem_rdata into the line, set tag, valid=1, dirty=0, and return to COMPARE. The request then hits on the next cycle; a pending write sets dirty at that point.
- proc_read and proc_write both high: treat as write.
- Requester must hold proc_read, proc_write, proc_addr and proc_wdata constant while proc_stall=1. The cache does not latch them.
- mem_ready seen in COMPARE is ignored.

## Timing
- Reset values: state=COMPARE, mem_read=0, mem_write=0. proc_stall=0 when no request is present. mem_addr and mem_wdata are don't-care while both requests are low.
- Hit latency: 0 extra cycles; serviced in the request cycle.
- Clean miss: 1 stall cycle in COMPARE + N ALLOCATE cycles (N = cycles until mem_ready, ≥1), then 1 COMPARE hit cycle with stall low.
- Dirty miss: 1 + W (writeback) + N (allocate) stall cycles, then the hit cycle.
- mem_read and mem_write are never high in the same cycle. Both are registered-state decoded.
- The memory request stays high in the cycle mem_ready is high and drops in the next cycle, unless WRITEBACK is moving straight into ALLOCATE.
- Reset mid-WRITEBACK or mid-ALLOCATE: the next cycle is COMPARE with both mem requests low and all lines invalid. A late mem_ready is ignored.
- Index wrap: lines whose addresses differ only in tag alias to the same line; conflict eviction is required behaviour.

## Test plan
- Cold read of proc_addr=0x00000010, memory returns 0xDDDD_CCCC_BBBB_AAAA_… after 3 cycles -> mem_read high with mem_addr=0x0000004; proc_rdata = word 0 with stall low on the 5th cycle. A following read of 0x00000011 hits with 0 stall.
- Write 0x12345678 to the resident word 0x00000011 -> no mem traffic and line dirty. Then read 0x00000111 (same index, different tag) -> mem_write with mem_addr=0x0000004 carrying 0x12345678 in [63:32], then mem_read at mem_addr=0x0000044.
- Clean conflict miss (line loaded, never written) -> no mem_write, only mem_read, total stall = 1 + N.
- Write miss to 0x00000022 -> allocate block, then word 2 = proc_wdata and dirty set. A later eviction writes back the merged block.
- Assert rst_n=0 for one cycle during ALLOCATE, then pulse mem_ready -> mem_read=0 after reset, no line becomes valid, and the next read of the same address misses again.
- mem_ready latency swept 1..8 cycles with random read/write traffic against a reference memory model -> every read returns model data and final memory matches after a flush-by-conflict sweep.
